// File: rtl/common_types_pkg.sv
// Shared types for the debug memory loader/dumper.
// Word type, sequencer states and word size in bytes.
package common_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        LOAD_IDLE,
        LOAD_WR,
        RUN,
        DUMP_RD,
        DUMP_OUT,
        DONE
    } loader_state_t;

    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/mem_loader_dumper.sv
// Debug RAM sequencer: loads a program image, runs the CPU until halt,
// then streams a fixed memory window out on a valid/ready port.
module mem_loader_dumper
    import common_types_pkg::*;
#(
    parameter logic [31:0] LOAD_BASE  = 32'h0000_0000,
    parameter logic [31:0] DUMP_BASE  = 32'h0000_0000,
    parameter int unsigned DUMP_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    output logic        cpu_nrst,
    input  logic        halt,
    output logic        override_ctrl,
    output logic        iren,
    output logic        dren,
    output logic        dwen,
    output logic [31:0] iaddr,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic        dwait,
    input  logic [31:0] dload,
    output logic        dp_valid,
    input  logic        dp_ready,
    output logic [31:0] dp_addr,
    output logic [31:0] dp_data,
    output logic        dp_last,
    output logic        done
);

    localparam int unsigned   CW       = $clog2(DUMP_WORDS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(DUMP_WORDS - 1);
    localparam word_t         STEP     = word_t'(WORD_BYTES);

    loader_state_t state_q, state_d;
    word_t         ptr_q, ptr_d;
    word_t         wdata_q, wdata_d;
    word_t         dout_q, dout_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          final_beat;

    assign final_beat = (cnt_q == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD_IDLE;
            ptr_q   <= LOAD_BASE;
            cnt_q   <= '0;
            wdata_q <= '0;
            last_q  <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            wdata_q <= wdata_d;
            last_q  <= last_d;
            dout_q  <= dout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        wdata_d = wdata_q;
        last_d  = last_q;
        dout_d  = dout_q;
        unique case (state_q)
            LOAD_IDLE: begin
                if (ld_valid) begin
                    wdata_d = ld_data;
                    last_d  = ld_last;
                    state_d = LOAD_WR;
                end
            end
            LOAD_WR: begin
                if (!dwait) begin
                    ptr_d   = ptr_q + STEP;
                    state_d = last_q ? RUN : LOAD_IDLE;
                end
            end
            RUN: begin
                // One pointer serves both phases; it is rebased for the dump here.
                if (halt) begin
                    ptr_d   = DUMP_BASE;
                    cnt_d   = '0;
                    state_d = DUMP_RD;
                end
            end
            DUMP_RD: begin
                if (!dwait) begin
                    dout_d  = dload;
                    state_d = DUMP_OUT;
                end
            end
            DUMP_OUT: begin
                if (dp_ready) begin
                    if (final_beat) begin
                        state_d = DONE;
                    end else begin
                        ptr_d   = ptr_q + STEP;
                        cnt_d   = cnt_q + CW'(1);
                        state_d = DUMP_RD;
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = LOAD_IDLE;
            end
        endcase
    end

    assign ld_ready      = (state_q == LOAD_IDLE);
    assign override_ctrl = (state_q != RUN);
    assign cpu_nrst      = (state_q == RUN);
    assign iren          = 1'b0;
    assign iaddr         = '0;
    assign dwen          = (state_q == LOAD_WR);
    assign dren          = (state_q == DUMP_RD);
    assign daddr         = (dwen || dren) ? ptr_q : '0;
    assign dstore        = dwen ? wdata_q : '0;
    assign dp_valid      = (state_q == DUMP_OUT);
    assign dp_addr       = dp_valid ? ptr_q : '0;
    assign dp_data       = dout_q;
    assign dp_last       = dp_valid && final_beat;
    assign done          = (state_q == DONE);

endmodule
